// File: rtl/ins_align_pkg.sv
// Shared types and helpers for the RV32IC fetch aligner.
package ins_align_pkg;

    typedef logic [15:0] hw_t;

    localparam logic [1:0] INS_32B = 2'b11;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } mem_req_t;

    function automatic logic is_compressed(hw_t hw);
        return hw[1:0] != INS_32B;
    endfunction

endpackage

// File: rtl/ins_hw_queue.sv
// Four-entry halfword shift queue: pop 0/1/2 from the head, push 0/1/2 behind the survivors.
module ins_hw_queue
    import ins_align_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [1:0] push_n,
    input  hw_t        push_d0,
    input  hw_t        push_d1,
    input  logic [1:0] pop_n,
    output hw_t        q0,
    output hw_t        q1,
    output logic [2:0] count
);

    logic [DEPTH-1:0][15:0] q, q_sh, q_nxt;
    logic [2:0]             cnt_pop, cnt_nxt;

    // Pop shifts the whole queue down; pushed halfwords land right after what survives.
    always_comb begin
        q_sh    = q >> {pop_n, 4'b0000};
        cnt_pop = count - {1'b0, pop_n};
        q_nxt   = q_sh;
        for (int i = 0; i < DEPTH; i++) begin
            if (push_n != 2'd0 && cnt_pop == 3'(i))
                q_nxt[i] = push_d0;
            if (push_n == 2'd2 && (cnt_pop + 3'd1) == 3'(i))
                q_nxt[i] = push_d1;
        end
        cnt_nxt = cnt_pop + {1'b0, push_n};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            q     <= q_nxt;
            count <= cnt_nxt;
        end
    end

    assign q0 = q[0];
    assign q1 = q[1];

endmodule

// File: rtl/ins_align_buf.sv
// Fetch aligner: word reads from instruction memory, one aligned 16/32-bit instruction out per handshake.
module ins_align_buf
    import ins_align_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BUF_HW   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        ins_valid,
    output logic [31:0] ins_data,
    output logic [31:0] ins_pc,
    output logic [1:0]  ins_2bit,
    output logic        ins_is_c,
    input  logic        ins_ready
);

    logic [31:0] head_pc, fetch_addr;
    logic        skip_low, outstanding, discard;

    hw_t         q0, q1;
    logic [2:0]  q_count;
    logic [1:0]  push_n, pop_n;
    hw_t         push_d0, push_d1;
    logic        head_c, out_vld, req_fire, rsp_take, pop_fire;
    mem_req_t    req;

    assign head_c  = is_compressed(q0);
    assign out_vld = (q_count >= 3'd1 && head_c) || (q_count >= 3'd2);

    always_comb begin
        req.valid = !rst && !outstanding && !discard && !redirect_en && (q_count <= 3'd2);
        req.addr  = rst ? 32'h0 : fetch_addr;
    end

    assign mem_req_valid = req.valid;
    assign mem_req_addr  = req.addr;
    assign req_fire      = req.valid && mem_req_ready;

    // A response is only buffered when it answers our own live request.
    assign rsp_take = mem_rsp_valid && outstanding && !discard && !redirect_en;
    assign push_n   = !rsp_take ? 2'd0 : (skip_low ? 2'd1 : 2'd2);
    assign push_d0  = skip_low ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    assign push_d1  = mem_rsp_data[31:16];

    assign pop_fire = out_vld && ins_ready && !redirect_en;
    assign pop_n    = !pop_fire ? 2'd0 : (head_c ? 2'd1 : 2'd2);

    always_comb begin
        ins_valid = out_vld;
        ins_data  = 32'h0;
        ins_pc    = 32'h0;
        ins_is_c  = 1'b0;
        if (out_vld) begin
            ins_data = head_c ? {16'h0, q0} : {q1, q0};
            ins_pc   = head_pc;
            ins_is_c = head_c;
        end
        ins_2bit = ins_data[1:0];
    end

    ins_hw_queue #(.DEPTH(BUF_HW)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .clear   (redirect_en),
        .push_n  (push_n),
        .push_d0 (push_d0),
        .push_d1 (push_d1),
        .pop_n   (pop_n),
        .q0      (q0),
        .q1      (q1),
        .count   (q_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_pc     <= RESET_PC;
            fetch_addr  <= {RESET_PC[31:2], 2'b00};
            skip_low    <= RESET_PC[1];
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end else if (redirect_en) begin
            head_pc     <= redirect_pc;
            fetch_addr  <= {redirect_pc[31:2], 2'b00};
            skip_low    <= redirect_pc[1];
            outstanding <= 1'b0;
            // Whatever is still in flight must be thrown away when it shows up.
            discard     <= (outstanding || discard) && !mem_rsp_valid;
        end else begin
            if (req_fire) begin
                outstanding <= 1'b1;
                fetch_addr  <= fetch_addr + 32'd4;
            end else if (mem_rsp_valid) begin
                outstanding <= 1'b0;
            end
            if (mem_rsp_valid && discard)
                discard <= 1'b0;
            if (rsp_take)
                skip_low <= 1'b0;
            if (pop_fire)
                head_pc <= head_pc + (head_c ? 32'd2 : 32'd4);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) q_count <= 3'(BUF_HW));

endmodule

// File: tb/tb_ins_align_buf.sv
// Self-checking bench: instruction stream model derived from memory contents and PC, plus directed scenarios.
module tb_ins_align_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic [1:0]  ins_2bit;
    logic        ins_is_c;
    logic        ins_ready;

    always #5 clk = ~clk;

    ins_align_buf dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .ins_valid     (ins_valid),
        .ins_data      (ins_data),
        .ins_pc        (ins_pc),
        .ins_2bit      (ins_2bit),
        .ins_is_c      (ins_is_c),
        .ins_ready     (ins_ready)
    );

    logic [31:0] ovr [logic [31:0]];
    int          tests = 0;
    int          fails = 0;

    // Abstract model: buffered halfword count, next expected PC, next expected fetch word.
    int          occ = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_req_addr = 32'h0;
    bit          skip = 1'b0;
    bit          pend_valid = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_wait = 0;
    int          pend_tag = 0;
    int          epoch = 0;
    bit          mem_hold = 1'b0;
    bit          lat_rand = 1'b0;
    int          hs_count = 0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        logic [31:0] x;
        if (ovr.exists(a)) return ovr[a];
        x = a ^ 32'h5bd1_e995;
        x = x * 32'h9E37_79B1;
        x = x ^ (x >> 15);
        x = x * 32'h85EB_CA6B;
        x = x ^ (x >> 13);
        return x;
    endfunction

    function automatic logic [15:0] mem_hw(logic [31:0] pc);
        logic [31:0] w;
        w = mem_word({pc[31:2], 2'b00});
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy, input bit mrdy);
        bit          rsp_now, exp_v, head_c, exp_rv, req_fire;
        logic [15:0] h0, h1;
        logic [31:0] exp_data;
        @(negedge clk);
        redirect_en   = redir;
        redirect_pc   = rpc;
        ins_ready     = rdy;
        mem_req_ready = mrdy;
        rsp_now = pend_valid && !mem_hold && pend_wait == 0;
        if (pend_valid && !mem_hold && pend_wait > 0) pend_wait--;
        mem_rsp_valid = rsp_now;
        mem_rsp_data  = rsp_now ? mem_word(pend_addr) : $urandom();
        #1;
        h0       = mem_hw(exp_pc);
        h1       = mem_hw(exp_pc + 32'd2);
        head_c   = (h0[1:0] != 2'b11);
        exp_v    = (occ >= 2) || (occ == 1 && head_c);
        exp_data = head_c ? {16'h0, h0} : {h1, h0};
        chk("ins_valid", 96'(ins_valid), 96'(exp_v));
        if (exp_v)
            chk("ins_out", 96'({ins_pc, ins_data, ins_2bit, ins_is_c}),
                96'({exp_pc, exp_data, exp_data[1:0], head_c}));
        else
            chk("ins_idle", 96'({ins_pc, ins_data, ins_2bit, ins_is_c}), 96'h0);
        exp_rv = !pend_valid && !redir && occ <= 2;
        chk("req_valid", 96'(mem_req_valid), 96'(exp_rv));
        if (mem_req_valid) chk("req_addr", 96'(mem_req_addr), 96'(exp_req_addr));
        req_fire = mem_req_valid && mrdy;
        if (rsp_now) pend_valid = 1'b0;
        if (redir) begin
            epoch++;
            occ          = 0;
            exp_pc       = rpc;
            skip         = rpc[1];
            exp_req_addr = {rpc[31:2], 2'b00};
        end else begin
            if (rsp_now && pend_tag == epoch) begin
                occ += skip ? 1 : 2;
                skip = 1'b0;
            end
            if (exp_v && rdy) begin
                occ    -= head_c ? 1 : 2;
                exp_pc += head_c ? 32'd2 : 32'd4;
                hs_count++;
            end
            if (req_fire) begin
                pend_valid   = 1'b1;
                pend_tag     = epoch;
                pend_addr    = mem_req_addr;
                pend_wait    = lat_rand ? int'($urandom_range(0, 3)) : 0;
                exp_req_addr += 32'd4;
            end
        end
    endtask

    task automatic quiesce();
        bit done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            done = !pend_valid && occ > 2;
        end
        if (!done) chk("quiesce_timeout", 96'd0, 96'd1);
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            seen = ins_valid;
        end
        if (!seen) chk({name, "_timeout"}, 96'd0, 96'd1);
    endtask

    initial begin
        bit seen;
        rst           = 1'b1;
        redirect_en   = 1'b0;
        redirect_pc   = 32'h0;
        ins_ready     = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        ovr[32'h0]    = 32'h0000_0013;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", 96'({mem_req_valid, mem_req_addr, ins_valid, ins_data, ins_pc, ins_2bit, ins_is_c}), 96'h0);
        rst = 1'b0;

        // Reset fetch of a single 32-bit instruction.
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t1_req0", 96'({mem_req_valid, mem_req_addr}), 96'({1'b1, 32'h0}));
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t1_ins", 96'({ins_valid, ins_data, ins_pc, ins_is_c}), 96'({1'b1, 32'h0000_0013, 32'h0, 1'b0}));
        chk("t1_req4", 96'({mem_req_valid, mem_req_addr}), 96'({1'b1, 32'h4}));

        // Compressed then straddling 32-bit instruction.
        quiesce();
        step(1'b1, 32'h0, 1'b0, 1'b1);
        ovr[32'h0] = 32'h0013_4505;
        ovr[32'h4] = 32'h0000_0000;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t2_first", 96'({ins_valid, ins_data, ins_pc, ins_is_c}), 96'({1'b1, 32'h0000_4505, 32'h0, 1'b1}));
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t2_wait", 96'(ins_valid), 96'd0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t2_second", 96'({ins_valid, ins_data, ins_pc, ins_is_c}), 96'({1'b1, 32'h0000_0013, 32'h2, 1'b0}));

        // Redirect to an odd halfword: low half of the word is skipped.
        quiesce();
        step(1'b1, 32'h102, 1'b0, 1'b1);
        ovr[32'h100] = 32'hABCD_0001;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t3_req", 96'({mem_req_valid, mem_req_addr}), 96'({1'b1, 32'h100}));
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t3_ins", 96'({ins_valid, ins_data, ins_pc, ins_is_c}), 96'({1'b1, 32'h0000_ABCD, 32'h102, 1'b1}));

        // Redirect while a request is in flight: its response is discarded.
        quiesce();
        step(1'b1, 32'h40, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t4_req40", 96'({mem_req_valid, mem_req_addr}), 96'({1'b1, 32'h40}));
        mem_hold = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h200, 1'b0, 1'b1);
        ovr[32'h200] = 32'h1234_5601;
        mem_hold = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            seen = mem_req_valid;
        end
        chk("t4_req200", 96'({seen, mem_req_addr}), 96'({1'b1, 32'h200}));
        wait_valid("t4_valid");
        chk("t4_ins", 96'({ins_pc, ins_data}), 96'({32'h200, 32'h0000_5601}));

        // Backpressure with compressed-only code.
        quiesce();
        step(1'b1, 32'h300, 1'b0, 1'b1);
        ovr[32'h300] = 32'h0009_0005;
        ovr[32'h304] = 32'h4501_4505;
        ovr[32'h308] = 32'h0001_0001;
        ovr[32'h30C] = 32'h0005_0009;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t5_stall", 96'({ins_valid, ins_pc, ins_data, mem_req_valid}), 96'({1'b1, 32'h300, 32'h0000_0005, 1'b0}));

        // Redirect in the same cycle as a handshake and a response.
        quiesce();
        step(1'b1, 32'h400, 1'b0, 1'b1);
        ovr[32'h400] = 32'h0005_0001;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t6_setup", 96'({ins_valid, mem_req_valid, mem_req_addr}), 96'({1'b1, 1'b1, 32'h404}));
        step(1'b1, 32'h500, 1'b1, 1'b1);
        chk("t6_collide_valid", 96'(ins_valid), 96'd1);
        ovr[32'h500] = 32'h0000_0001;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t6_req500", 96'({ins_valid, mem_req_valid, mem_req_addr}), 96'({1'b0, 1'b1, 32'h500}));
        wait_valid("t6_valid");
        chk("t6_ins", 96'({ins_pc, ins_data}), 96'({32'h500, 32'h0000_0001}));

        // Randomized traffic against the model.
        lat_rand = 1'b1;
        hs_count = 0;
        for (int c = 0; c < 4000; c++) begin
            bit          r;
            logic [31:0] pc;
            r  = ($urandom_range(0, 39) == 0);
            pc = 32'($urandom_range(0, 8191)) << 1;
            step(r, pc, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        chk("rand_progress", 96'(hs_count > 300), 96'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ins_align_buf.md
Name: ins_align_buf

Overview:
- Fetch-side instruction aligner for the RV32IC front end.
- Issues word-aligned reads to instruction memory and buffers the returned halfwords.
- Delivers one aligned instruction per handshake: 16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary.
- Its outputs carry the instruction, the low 2 bits and the PC that PcCtrl uses to compute next_pc. Taken jumps arrive back as a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset; bit 0 must be 0.
- BUF_HW, 4, halfword buffer depth; fixed at 4, kept as a parameter for assertions only.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_en  in  1  taken jump or flush.
- redirect_pc  in  32  new PC; bit 0 is 0.
- mem_req_valid  out  1  read request.
- mem_req_addr  out  32  word-aligned read address.
- mem_req_ready  in  1  request accepted when high with mem_req_valid.
- mem_rsp_valid  in  1  read data valid; one response per accepted request, in order, latency ≥1 cycle.
- mem_rsp_data  in  32  read data, little-endian.
- ins_valid  out  1  instruction available.
- ins_data  out  32  instruction; compressed instructions are zero-extended {16'h0, hw}.
- ins_pc  out  32  PC of ins_data.
- ins_2bit  out  2  ins_data[1:0].
- ins_is_c  out  1  compressed flag, ins_2bit != 2'b11.
- ins_ready  in  1  consumer accepts when high with ins_valid.

Behaviour:
- Reset (async, rst=1):
  - count=0, head_pc=RESET_PC, fetch_addr={RESET_PC[31:2],2'b00}.
  - skip_low=RESET_PC[1]; outstanding=0; discard=0.
  - All outputs 0.
- State:
  - 4-entry halfword queue; count 0..4.
  - head_pc (PC of the queue head), fetch_addr, skip_low.
  - outstanding: a request has been accepted and its response has not yet returned.
  - discard: the next response is stale.
- Request:
  - mem_req_valid = !outstanding & !discard & !redirect_en & (count ≤ 2).
  - mem_req_addr = fetch_addr.
  - On acceptance: outstanding=1 and fetch_addr += 4, wrapping modulo 2^32.
  - Withdrawing a request in the redirect cycle is legal on this bus.
- Response:
  - If discard=1: drop the data and clear discard.
  - Otherwise push {hi, lo} as two halfwords, or hi only if skip_low=1, then clear skip_low.
  - Clear outstanding.
- Output (combinational from registered state):
  - ins_is_c = (q[0][1:0] != 2'b11).
  - ins_valid = (count ≥ 1 & ins_is_c) | (count ≥ 2).
  - ins_data = ins_is_c ? {16'h0, q[0]} : {q[1], q[0]}.
  - ins_pc = head_pc.
  - When ins_valid=0, ins_data, ins_2bit, ins_is_c and ins_pc are driven 0.
- Pop:
  - On ins_valid & ins_ready, pop 1 halfword (compressed) or 2, and advance head_pc by 2 or 4, wrapping.
- Simultaneous push and pop in one cycle: count_next = count + pushed − popped. count ≤ 2 at request time guarantees no overflow.
- Redirect (highest priority):
  - Queue cleared (count=0); head_pc=redirect_pc.
  - fetch_addr={redirect_pc[31:2],2'b00}; skip_low=redirect_pc[1].
  - Any pop or response arriving in the same cycle is ignored.
  - If outstanding=1 and no response arrives this cycle: discard=1.
  - outstanding=0 in all cases.
- Latency:
  - Redirect at cycle T; request at T+1.
  - With mem_req_ready=1 and 1-cycle memory, data arrives at T+2 and ins_valid rises at T+3.
- Backpressure: with ins_ready=0 the outputs stay stable and at most one further word is fetched, until count > 2.
- Reset mid-transfer: in-flight memory responses after reset are the bus owner's responsibility; the block treats the first response after reset as valid only if it issued a request.

Decomposition:
- Package ins_align_pkg holds:
  - typedef hw_t (logic [15:0]).
  - Constant INS_32B = 2'b11.
  - Function is_compressed(hw_t).
- One sub-module, ins_hw_queue: 4-entry halfword shift queue with push 0/1/2, pop 0/1/2, clear and count.

Test Plan:
- Reset with RESET_PC=0, mem[0]=32'h0000_0013 -> mem_req_addr=0 at cycle 1; ins_valid with ins_data=32'h0000_0013, ins_pc=0, ins_is_c=0; next request addr=4.
- Straddle: mem[0]=32'h0013_4505, mem[4]=32'h0000_0000 -> first instruction pc=0, ins_data=32'h0000_4505, is_c=1; second instruction pc=2, ins_data=32'h0000_0013, is_c=0.
- Redirect to 32'h0000_0102 with mem[0x100]=32'hABCD_0001 -> req addr 0x100; low half dropped; ins_pc=0x102, ins_data=32'h0000_ABCD, is_c=1.
- Redirect to 0x200 while the request for 0x40 is outstanding -> the 0x40 response is discarded; the next request is 0x200 and the first ins_pc is 0x200.
- ins_ready=0 for 10 cycles with compressed-only code -> ins_data/ins_pc stable; no request while count > 2.
- redirect_en in the same cycle as an ins handshake and mem_rsp_valid -> no pop, data dropped, discard stays 0, the next request is to the redirect word.
